// File: rtl/cpe_pkg.sv
// cpe_pkg: shared types and arithmetic helpers for the compensation PE family.
//   buf_state_t  - weight double-buffer occupancy (shadow / active)
//   ARITH_W      - working width of the accumulation helper
//   prod_width() - width of the odd-reconstructed product
//   sat_add()    - psum + prod with overflow detect, saturate or wrap
package cpe_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY  = 2'd0,
        BUF_SHADOW = 2'd1,
        BUF_ACTIVE = 2'd2,
        BUF_BOTH   = 2'd3
    } buf_state_t;

    // Operands are zero-extended to this width; psum_w must stay below it.
    localparam int ARITH_W = 32;

    // {w,1} x {act,1}: each operand grows by one bit.
    function automatic int prod_width(input int cw_w, input int act_w);
        return cw_w + act_w + 2;
    endfunction

    // Returns {ovf, result}. Overflow means the true sum does not fit in
    // psum_w bits; the result is then all-ones (sat_en) or the low bits.
    function automatic logic [ARITH_W:0] sat_add(
        input logic [ARITH_W-1:0] psum,
        input logic [ARITH_W-1:0] prod,
        input int                 psum_w,
        input logic               sat_en
    );
        logic [ARITH_W:0] sum_v;
        logic [ARITH_W:0] limit_v;
        logic [ARITH_W:0] mask_v;
        logic [ARITH_W:0] res_v;
        logic             ovf_v;
        sum_v   = {1'b0, psum} + {1'b0, prod};
        limit_v = {{ARITH_W{1'b0}}, 1'b1} << psum_w;
        mask_v  = limit_v - {{ARITH_W{1'b0}}, 1'b1};
        ovf_v   = (sum_v >= limit_v);
        if (!ovf_v) begin
            res_v = sum_v;
        end else if (sat_en) begin
            res_v = mask_v;
        end else begin
            res_v = sum_v & mask_v;
        end
        return {ovf_v, res_v[ARITH_W-1:0]};
    endfunction

endpackage

// File: rtl/cpe_mac.sv
// cpe_mac: combinational odd-reconstruction multiply-accumulate.
//   w    [CW_W]   weight magnitude code (LSB 1 appended internally)
//   act  [ACT_W]  activation magnitude code (LSB 1 appended internally)
//   psum [PSUM_W] incoming partial sum
//   sum  [PSUM_W] psum + prod, saturated or wrapped by SAT_EN
//   ovf           true sum did not fit in PSUM_W bits
module cpe_mac
    import cpe_pkg::*;
#(
    parameter int CW_W   = 3,
    parameter int ACT_W  = 7,
    parameter int PSUM_W = 14,
    parameter int SAT_EN = 0
) (
    input  logic [CW_W-1:0]   w,
    input  logic [ACT_W-1:0]  act,
    input  logic [PSUM_W-1:0] psum,
    output logic [PSUM_W-1:0] sum,
    output logic              ovf
);

    localparam int PROD_W = prod_width(CW_W, ACT_W);

    logic [PROD_W-1:0]  prod_s;
    logic [ARITH_W:0]   add_s;
    logic               unused_hi_s;

    // Both operands are zero-extended to PROD_W so the product is full width.
    assign prod_s = {{(ACT_W+1){1'b0}}, w, 1'b1} * {{(CW_W+1){1'b0}}, act, 1'b1};

    assign add_s = sat_add({{(ARITH_W-PSUM_W){1'b0}}, psum},
                           {{(ARITH_W-PROD_W){1'b0}}, prod_s},
                           PSUM_W, (SAT_EN != 0));

    assign sum         = add_s[PSUM_W-1:0];
    assign ovf         = add_s[ARITH_W];
    // Upper result bits are always zero once the result is reduced to PSUM_W.
    assign unused_hi_s = ^add_s[ARITH_W-1:PSUM_W];

endmodule

// File: rtl/cpe_dbuf.sv
// cpe_dbuf: compensation PE with double-buffered weight.
//   clk, rst_n                  clock, asynchronous active-low reset
//   w_in/w_in_valid             weight preload chain input
//   w_swap                      move shadow weight into active register
//   act_in/act_in_valid         activation from left neighbour
//   psum_in/psum_in_valid       partial sum from upstream PE
//   sat_clr                     clear sticky overflow flag
//   w_out/w_out_valid           registered preload chain output
//   act_out/act_out_valid       registered activation pass-through
//   psum_out/psum_out_valid     registered partial sum (MAC or pass)
//   w_active_valid              active register holds a loaded weight
//   sat_flag                    sticky saturation/wrap indicator
module cpe_dbuf
    import cpe_pkg::*;
#(
    parameter int CW_W   = 3,
    parameter int ACT_W  = 7,
    parameter int PSUM_W = 14,
    parameter int SAT_EN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   w_in,
    input  logic              w_in_valid,
    input  logic              w_swap,
    input  logic [ACT_W-1:0]  act_in,
    input  logic              act_in_valid,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_in_valid,
    input  logic              sat_clr,
    output logic [CW_W-1:0]   w_out,
    output logic              w_out_valid,
    output logic [ACT_W-1:0]  act_out,
    output logic              act_out_valid,
    output logic [PSUM_W-1:0] psum_out,
    output logic              psum_out_valid,
    output logic              w_active_valid,
    output logic              sat_flag
);

    buf_state_t        state_r;
    buf_state_t        state_nx_s;
    logic [CW_W-1:0]   shadow_r;
    logic [CW_W-1:0]   active_r;
    logic              shadow_full_s;
    logic              active_valid_s;
    logic              swap_ok_s;
    logic              mac_s;
    logic [PSUM_W-1:0] mac_sum_s;
    logic              mac_ovf_s;
    logic [PSUM_W-1:0] psum_nx_s;
    logic              flag_nx_s;

    logic [CW_W-1:0]   w_out_r;
    logic              w_out_valid_r;
    logic [ACT_W-1:0]  act_out_r;
    logic              act_out_valid_r;
    logic [PSUM_W-1:0] psum_out_r;
    logic              psum_out_valid_r;
    logic              w_active_valid_r;
    logic              sat_flag_r;

    assign shadow_full_s  = (state_r == BUF_SHADOW) || (state_r == BUF_BOTH);
    assign active_valid_s = (state_r == BUF_ACTIVE) || (state_r == BUF_BOTH);
    assign swap_ok_s      = w_swap && shadow_full_s;
    assign mac_s          = act_in_valid && active_valid_s;

    cpe_mac #(
        .CW_W   (CW_W),
        .ACT_W  (ACT_W),
        .PSUM_W (PSUM_W),
        .SAT_EN (SAT_EN)
    ) u_mac (
        .w    (active_r),
        .act  (act_in),
        .psum (psum_in),
        .sum  (mac_sum_s),
        .ovf  (mac_ovf_s)
    );

    // Buffer occupancy next state; a swap with an empty shadow is ignored.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            BUF_EMPTY: begin
                if (w_in_valid) state_nx_s = BUF_SHADOW;
                else            state_nx_s = BUF_EMPTY;
            end
            BUF_SHADOW: begin
                // Simultaneous preload refills the shadow just emptied.
                if (w_swap) state_nx_s = w_in_valid ? BUF_BOTH : BUF_ACTIVE;
                else        state_nx_s = BUF_SHADOW;
            end
            BUF_ACTIVE: begin
                if (w_in_valid) state_nx_s = BUF_BOTH;
                else            state_nx_s = BUF_ACTIVE;
            end
            BUF_BOTH: begin
                if (w_swap && !w_in_valid) state_nx_s = BUF_ACTIVE;
                else                       state_nx_s = BUF_BOTH;
            end
            default: state_nx_s = BUF_EMPTY;
        endcase
    end

    // Compute result and sticky-flag next values; set wins over clear.
    always_comb begin
        psum_nx_s = psum_in;
        flag_nx_s = sat_flag_r;
        if (mac_s) begin
            psum_nx_s = mac_sum_s;
        end else begin
            psum_nx_s = psum_in;
        end
        if (mac_s && mac_ovf_s) begin
            flag_nx_s = 1'b1;
        end else if (sat_clr) begin
            flag_nx_s = 1'b0;
        end else begin
            flag_nx_s = sat_flag_r;
        end
    end

    // Buffer state, shadow and active weight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= BUF_EMPTY;
            shadow_r         <= {CW_W{1'b0}};
            active_r         <= {CW_W{1'b0}};
            w_active_valid_r <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            // Swap reads the pre-edge shadow, so a same-cycle preload is safe.
            shadow_r         <= w_in_valid ? w_in : shadow_r;
            active_r         <= swap_ok_s ? shadow_r : active_r;
            w_active_valid_r <= (state_nx_s == BUF_ACTIVE) || (state_nx_s == BUF_BOTH);
        end
    end

    // Pass-through and result pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out_r          <= {CW_W{1'b0}};
            w_out_valid_r    <= 1'b0;
            act_out_r        <= {ACT_W{1'b0}};
            act_out_valid_r  <= 1'b0;
            psum_out_r       <= {PSUM_W{1'b0}};
            psum_out_valid_r <= 1'b0;
            sat_flag_r       <= 1'b0;
        end else begin
            w_out_r          <= w_in;
            w_out_valid_r    <= w_in_valid;
            act_out_r        <= act_in;
            act_out_valid_r  <= act_in_valid;
            psum_out_r       <= psum_nx_s;
            psum_out_valid_r <= psum_in_valid;
            sat_flag_r       <= flag_nx_s;
        end
    end

    assign w_out          = w_out_r;
    assign w_out_valid    = w_out_valid_r;
    assign act_out        = act_out_r;
    assign act_out_valid  = act_out_valid_r;
    assign psum_out       = psum_out_r;
    assign psum_out_valid = psum_out_valid_r;
    assign w_active_valid = w_active_valid_r;
    assign sat_flag       = sat_flag_r;

endmodule

// File: tb/tb_cpe_dbuf.sv
// tb_cpe_dbuf: directed plus randomized checks of cpe_dbuf, one wrapping and
// one saturating instance driven in parallel, against a behavioural model.
module tb_cpe_dbuf;

    localparam int CW_W   = 3;
    localparam int ACT_W  = 7;
    localparam int PSUM_W = 14;
    localparam int PMAX   = 1 << PSUM_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CW_W-1:0]   w_in = '0;
    logic              w_in_valid = 1'b0;
    logic              w_swap = 1'b0;
    logic [ACT_W-1:0]  act_in = '0;
    logic              act_in_valid = 1'b0;
    logic [PSUM_W-1:0] psum_in = '0;
    logic              psum_in_valid = 1'b0;
    logic              sat_clr = 1'b0;

    logic [CW_W-1:0]   w_out_a, w_out_b;
    logic              w_out_valid_a, w_out_valid_b;
    logic [ACT_W-1:0]  act_out_a, act_out_b;
    logic              act_out_valid_a, act_out_valid_b;
    logic [PSUM_W-1:0] psum_out_a, psum_out_b;
    logic              psum_out_valid_a, psum_out_valid_b;
    logic              w_active_valid_a, w_active_valid_b;
    logic              sat_flag_a, sat_flag_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int m_shadow, m_active;
    bit m_shfull, m_aval, m_flag;

    always #5 clk = ~clk;

    cpe_dbuf #(.CW_W(CW_W), .ACT_W(ACT_W), .PSUM_W(PSUM_W), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .w_in(w_in), .w_in_valid(w_in_valid), .w_swap(w_swap),
        .act_in(act_in), .act_in_valid(act_in_valid), .psum_in(psum_in),
        .psum_in_valid(psum_in_valid), .sat_clr(sat_clr),
        .w_out(w_out_a), .w_out_valid(w_out_valid_a), .act_out(act_out_a),
        .act_out_valid(act_out_valid_a), .psum_out(psum_out_a),
        .psum_out_valid(psum_out_valid_a), .w_active_valid(w_active_valid_a),
        .sat_flag(sat_flag_a)
    );

    cpe_dbuf #(.CW_W(CW_W), .ACT_W(ACT_W), .PSUM_W(PSUM_W), .SAT_EN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .w_in(w_in), .w_in_valid(w_in_valid), .w_swap(w_swap),
        .act_in(act_in), .act_in_valid(act_in_valid), .psum_in(psum_in),
        .psum_in_valid(psum_in_valid), .sat_clr(sat_clr),
        .w_out(w_out_b), .w_out_valid(w_out_valid_b), .act_out(act_out_b),
        .act_out_valid(act_out_valid_b), .psum_out(psum_out_b),
        .psum_out_valid(psum_out_valid_b), .w_active_valid(w_active_valid_b),
        .sat_flag(sat_flag_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_shfull = 0; m_aval = 0; m_flag = 0;
    endtask

    task automatic drive(input bit wv, input int w, input bit sw, input bit av,
                         input int a, input bit pv, input int p, input bit clr);
        w_in_valid = wv; w_in = w[CW_W-1:0]; w_swap = sw;
        act_in_valid = av; act_in = a[ACT_W-1:0];
        psum_in_valid = pv; psum_in = p[PSUM_W-1:0]; sat_clr = clr;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_psum_a"}, 32'(psum_out_a), 32'd0);
        chk({tag, "_psum_b"}, 32'(psum_out_b), 32'd0);
        chk({tag, "_pval"},   32'({psum_out_valid_a, psum_out_valid_b}), 32'd0);
        chk({tag, "_act"},    32'({act_out_a, act_out_b, act_out_valid_a, act_out_valid_b}), 32'd0);
        chk({tag, "_w"},      32'({w_out_a, w_out_b, w_out_valid_a, w_out_valid_b}), 32'd0);
        chk({tag, "_aval"},   32'({w_active_valid_a, w_active_valid_b}), 32'd0);
        chk({tag, "_flag"},   32'({sat_flag_a, sat_flag_b}), 32'd0);
    endtask

    // One clock: predict from the pre-edge model state, clock, then compare.
    task automatic step(input string tag);
        int s, e_wrap, e_sat, e_w, e_act;
        bit ovf, e_wv, e_av, e_pv;
        ovf = 0;
        if (act_in_valid && m_aval) begin
            s = int'(psum_in) + (2 * m_active + 1) * (2 * int'(act_in) + 1);
            ovf = (s >= PMAX);
            e_wrap = s % PMAX;
            e_sat  = ovf ? PMAX - 1 : s;
        end else begin
            e_wrap = int'(psum_in);
            e_sat  = int'(psum_in);
        end
        if (ovf) m_flag = 1;
        else if (sat_clr) m_flag = 0;
        e_w = int'(w_in); e_wv = w_in_valid;
        e_act = int'(act_in); e_av = act_in_valid; e_pv = psum_in_valid;
        if (w_swap && m_shfull) begin
            m_active = m_shadow; m_aval = 1; m_shfull = 0;
        end
        if (w_in_valid) begin
            m_shadow = int'(w_in); m_shfull = 1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_psum_wrap"}, 32'(psum_out_a), 32'(e_wrap));
        chk({tag, "_psum_sat"},  32'(psum_out_b), 32'(e_sat));
        chk({tag, "_psum_val"},  32'({psum_out_valid_a, psum_out_valid_b}), 32'({e_pv, e_pv}));
        chk({tag, "_act_out"},   32'(act_out_a), 32'(e_act));
        chk({tag, "_act_val"},   32'(act_out_valid_b), 32'(e_av));
        chk({tag, "_w_out"},     32'(w_out_b), 32'(e_w));
        chk({tag, "_w_val"},     32'(w_out_valid_a), 32'(e_wv));
        chk({tag, "_aval"},      32'({w_active_valid_a, w_active_valid_b}), 32'({m_aval, m_aval}));
        chk({tag, "_flag"},      32'({sat_flag_a, sat_flag_b}), 32'({m_flag, m_flag}));
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        // Reset held with random inputs: outputs stay 0.
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom), $urandom, 1'($urandom));
            @(posedge clk); #1;
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 5, 1, 100, 0);
        step("release");
        chk("release_lit", 32'(psum_out_a), 32'd100);

        // Basic MAC: w=3 -> 7 x 11 + 100
        drive(1, 3, 0, 0, 0, 0, 0, 0); step("pre3");
        drive(0, 0, 1, 0, 0, 0, 0, 0); step("swap3");
        drive(0, 0, 0, 1, 5, 1, 100, 0); step("mac3");
        chk("basic_lit", 32'(psum_out_a), 32'd177);

        // Preload 6 while computing, then swap in the same cycle as compute.
        drive(1, 6, 0, 1, 5, 1, 100, 0); step("pre6_mac");
        chk("conc_lit", 32'(psum_out_b), 32'd177);
        drive(0, 0, 1, 1, 5, 1, 100, 0); step("swap6_mac");
        chk("swapmac_lit", 32'(psum_out_a), 32'd177);
        drive(0, 0, 0, 1, 5, 1, 100, 0); step("mac6");
        chk("mac6_lit", 32'(psum_out_a), 32'd243);

        // Overflow: w=7, act=127, psum=16000
        drive(1, 7, 0, 0, 0, 0, 0, 0); step("pre7");
        drive(0, 0, 1, 0, 0, 0, 0, 0); step("swap7");
        drive(0, 0, 0, 1, 127, 1, 16000, 0); step("ovf");
        chk("sat_lit",  32'(psum_out_b), 32'd16383);
        chk("wrap_lit", 32'(psum_out_a), 32'd3441);
        chk("flag_lit", 32'(sat_flag_a), 32'd1);
        drive(0, 0, 0, 1, 127, 1, 16000, 1); step("ovf_clr");
        chk("setwins_lit", 32'(sat_flag_b), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1); step("clr");
        chk("clr_lit", 32'(sat_flag_a), 32'd0);

        // Asynchronous reset mid-tile, checked before the next clock edge.
        drive(1, 2, 0, 1, 9, 1, 50, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Swap with empty shadow is ignored.
        drive(0, 0, 1, 0, 0, 0, 0, 0); step("swap_empty");
        chk("swap_empty_lit", 32'(w_active_valid_a), 32'd0);
        drive(0, 0, 0, 1, 5, 1, 100, 0); step("no_weight");
        chk("no_weight_lit", 32'(psum_out_a), 32'd100);
        // Preload 2, then preload 4 together with swap -> active 2, shadow 4.
        drive(1, 2, 0, 0, 0, 0, 0, 0); step("pre2");
        drive(1, 4, 1, 0, 0, 0, 0, 0); step("pre4_swap");
        drive(0, 0, 0, 1, 5, 1, 100, 0); step("mac2");
        chk("mac2_lit", 32'(psum_out_a), 32'd155);
        drive(0, 0, 1, 0, 0, 0, 0, 0); step("swap4");
        drive(0, 0, 0, 1, 5, 1, 100, 0); step("mac4");
        chk("mac4_lit", 32'(psum_out_a), 32'd199);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, PMAX - 1)), ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpe_dbuf.md
# cpe_dbuf

Parametrised compensation processing element for the systolic array. Each compensation column is a chain of these blocks. Each one multiplies an odd-reconstructed compensation weight by an odd-reconstructed activation and adds the product to the incoming compensation partial sum. Unlike the previous CPE, it double-buffers the weight (shadow plus active), so the next tile's weights preload while the current tile computes. It also registers all pass-through paths, tracks buffer occupancy with a small FSM, and optionally saturates the accumulation.

## Interface
Parameters:
- CW_W, 3, compensation weight width (magnitude code)
- ACT_W, 7, activation width (magnitude code)
- PSUM_W, 14, partial-sum width (unsigned)
- SAT_EN, 0, 1 = saturate psum at 2^PSUM_W−1, 0 = wrap modulo 2^PSUM_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_in  in  CW_W  weight from upstream PE in the preload chain
- w_in_valid  in  1  w_in is valid this cycle
- w_swap  in  1  pulse: move shadow weight into active register
- act_in  in  ACT_W  activation from left neighbour
- act_in_valid  in  1  act_in is valid
- psum_in  in  PSUM_W  partial sum from upstream PE
- psum_in_valid  in  1  psum_in is valid
- sat_clr  in  1  clear the sticky saturation flag
- w_out  out  CW_W  registered weight to downstream PE
- w_out_valid  out  1  registered copy of w_in_valid
- act_out  out  ACT_W  registered activation to right neighbour
- act_out_valid  out  1  registered act_in_valid
- psum_out  out  PSUM_W  registered partial sum
- psum_out_valid  out  1  registered psum_in_valid
- w_active_valid  out  1  active weight register holds a loaded weight
- sat_flag  out  1  sticky flag: a saturation or wrap event occurred

## Operation
- Weight preload:
  - When w_in_valid, shadow ← w_in, and w_out ← w_in with w_out_valid ← 1.
  - Each valid beat overwrites the shadow, so after N beats each PE in an N-deep chain holds its own weight.
- Swap:
  - When w_swap and the shadow is full: active ← shadow, shadow becomes empty.
  - When w_swap and the shadow is empty: ignored, and active is unchanged.
- FSM over {shadow_full, active_valid}:
  - EMPTY → (w_in_valid) SHADOW.
  - SHADOW → (w_swap) ACTIVE.
  - ACTIVE → (w_in_valid) BOTH.
  - BOTH → (w_swap) ACTIVE.
  - Active never returns to invalid except on reset.
  - w_in_valid and w_swap in the same cycle: the swap uses the pre-edge shadow, the new w_in lands in the shadow, and the next state is BOTH.
- Compute, registered:
  - prod = {w_act,1'b1} × {act_in,1'b1}, width CW_W+ACT_W+2.
  - If act_in_valid and w_active_valid: sum = psum_in + prod, computed at PSUM_W+1 bits or wider.
  - If act_in_valid and the active weight is invalid: psum_out ← psum_in; the product is treated as 0.
  - If act_in_valid is low: psum_out ← psum_in, pure pass.
  - Overflow (sum ≥ 2^PSUM_W): with SAT_EN=1, psum_out ← all-ones; with SAT_EN=0, psum_out ← low PSUM_W bits. In both cases sat_flag ← 1.
- Compute and swap in the same cycle: the compute uses the pre-edge active weight, and the new weight applies from the next cycle.
- Preload and compute are fully concurrent; neither has priority over the other.
- sat_flag:
  - sat_clr clears it.
  - A simultaneous overflow and sat_clr leaves the flag set, because set wins.

## Timing
- All outputs are registered with a latency of 1 cycle, input edge to output.
- w_out_valid, act_out_valid and psum_out_valid are 1-cycle delayed copies of their inputs. Data registers always load their input; consumers qualify by valid.
- Reset (rst_n=0, asynchronous): every output = 0, shadow = 0, active = 0, FSM = EMPTY.
  - Reset asserted mid-preload or mid-tile discards all weights and in-flight sums.
  - The first edge after deassertion behaves as a normal cycle.
- w_active_valid rises one cycle after the accepted swap edge.

## Structure
- cpe_pkg:
  - buffer-state enum (EMPTY, SHADOW, ACTIVE, BOTH)
  - localparam helper for PROD_W = CW_W+ACT_W+2
  - function sat_add(psum, prod, sat_en) returning {ovf, result}
- Sub-module cpe_mac: the combinational odd-reconstruction multiply plus sat_add. It is reused later by the wide multi-lane CPE.
- cpe_dbuf holds the FSM, the shadow and active registers, and the output pipeline registers.

## Test plan
- Reset/idle: hold rst_n=0 and drive random inputs → all outputs 0 and FSM EMPTY. Release with act_in_valid=1, act_in=5, psum_in=100 → psum_out=100, because no active weight is loaded.
- Basic MAC: preload w=3, swap, then act=5, psum_in=100 → {3,1}=7 and {5,1}=11, so psum_out=177 one cycle later, psum_out_valid=1.
- Concurrent preload and swap timing:
  - Active w=3 and w_in=6 preloading while act=5 streams → results stay 177.
  - Swap in the same cycle as act=5 → that beat still gives 177.
  - Next act=5 → 13×11+100 = 243.
- Saturation, SAT_EN=1: w=7, act=127, psum_in=16000 → 15×255 = 3825, so psum_out=16383 and sat_flag=1.
- Wrap, SAT_EN=0: the same stimulus gives psum_out=3441 and sat_flag=1. sat_clr together with a second overflow leaves flag=1; sat_clr alone clears it.
- Swap edge cases:
  - Swap with an empty shadow → ignored, w_active_valid stays 0.
  - w_in_valid plus swap in the SHADOW state → next state BOTH.
  - Assert rst_n=0 mid-tile → all state clears asynchronously, before the next clk edge.
